// File: rtl/branch_resolve_stage_pkg.sv
// Shared definitions for the branch resolution stage: condition-code
// encodings, FSM state enum, squash counter width and a saturating increment.
package branch_resolve_stage_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      BR_EQ  = 3'b000,
      BR_NE  = 3'b001,
      BR_LT  = 3'b010,
      BR_GE  = 3'b011,
      BR_GT  = 3'b100,
      BR_LE  = 3'b101,
      BR_JMP = 3'b110,
      BR_RSV = 3'b111
   } br_op_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SQUASH = 1'b1
   } state_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/branch_resolve_stage_if.sv
// Bus between the EX-stage comparator / front-end and the branch resolution
// stage. master = upstream/downstream environment, slave = the stage itself.
interface branch_resolve_stage_if #(
   parameter int ADDR_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic              is_branch;
   logic [2:0]        br_op;
   logic              cmp_eq;
   logic              cmp_lt;
   logic              cmp_gt;
   logic              pred_taken;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] offset;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic              taken;
   logic [ADDR_W-1:0] next_pc;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic [31:0]       stat_branches;
   logic [31:0]       stat_mispred;

   modport master (
      output in_valid, is_branch, br_op, cmp_eq, cmp_lt, cmp_gt, pred_taken,
             pc, offset, flush, out_ready,
      input  in_ready, out_valid, taken, next_pc, redirect, redirect_pc,
             stat_branches, stat_mispred
   );

   modport slave (
      input  in_valid, is_branch, br_op, cmp_eq, cmp_lt, cmp_gt, pred_taken,
             pc, offset, flush, out_ready,
      output in_ready, out_valid, taken, next_pc, redirect, redirect_pc,
             stat_branches, stat_mispred
   );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: maps the condition code and the
// comparator flags to a single "condition holds" bit.
module branch_cond_eval
   import branch_resolve_stage_pkg::*;
(
   input  logic [2:0] br_op_i,
   input  logic       cmp_eq_i,
   input  logic       cmp_lt_i,
   input  logic       cmp_gt_i,
   output logic       cond_o
);

   // Decode the condition code; the reserved code never takes.
   always_comb begin
      cond_o = 1'b0;
      case (br_op_i)
         BR_EQ:   cond_o = cmp_eq_i;
         BR_NE:   cond_o = ~cmp_eq_i;
         BR_LT:   cond_o = cmp_lt_i;
         BR_GE:   cond_o = cmp_gt_i | cmp_eq_i;
         BR_GT:   cond_o = cmp_gt_i;
         BR_LE:   cond_o = cmp_lt_i | cmp_eq_i;
         BR_JMP:  cond_o = 1'b1;
         default: cond_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_stage.sv
// Registered branch resolution stage: resolves direction and next PC,
// checks the front-end prediction, pulses a redirect on a mispredict and
// drops the following SQUASH_CYC wrong-path inputs.
// Optional feature: define BRANCH_STATS_EN to build the saturating
// branch / mispredict counters; otherwise stat_* are tied to zero.
module branch_resolve_stage
   import branch_resolve_stage_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int PC_STEP    = 1,
   parameter int SQUASH_CYC = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   branch_resolve_stage_if.slave  bus
);

   localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
   localparam logic [CNT_W-1:0]  SQ_INIT = CNT_W'(SQUASH_CYC);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               out_valid_q;
   logic               taken_q;
   logic               redirect_q;
   logic [ADDR_W-1:0]  next_pc_q;
   logic [ADDR_W-1:0]  redirect_pc_q;

   logic               cond;
   logic               in_ready;
   logic               run_acc;
   logic               mispred;
   logic               taken_d;
   logic [ADDR_W-1:0]  next_pc_d;

   branch_cond_eval u_cond (
      .br_op_i  (bus.br_op),
      .cmp_eq_i (bus.cmp_eq),
      .cmp_lt_i (bus.cmp_lt),
      .cmp_gt_i (bus.cmp_gt),
      .cond_o   (cond)
   );

   // While squashing every input is swallowed, so the stage is always ready.
   assign in_ready  = (state_q == ST_SQUASH) | ~out_valid_q | bus.out_ready;
   assign run_acc   = bus.in_valid & in_ready & (state_q == ST_RUN);
   assign taken_d   = bus.is_branch & cond;
   assign next_pc_d = taken_d ? (bus.pc + bus.offset) : (bus.pc + STEP);
   assign mispred   = bus.is_branch & (taken_d != bus.pred_taken);

   // Output register, redirect pulse and RUN/SQUASH control; flush overrides all.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_RUN;
         cnt_q         <= '0;
         out_valid_q   <= 1'b0;
         taken_q       <= 1'b0;
         redirect_q    <= 1'b0;
         next_pc_q     <= '0;
         redirect_pc_q <= '0;
      end else begin
         redirect_q <= 1'b0;
         if (bus.flush) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_RUN;
            cnt_q       <= '0;
         end else begin
            if (out_valid_q & bus.out_ready) out_valid_q <= 1'b0;
            case (state_q)
               ST_RUN: begin
                  if (run_acc) begin
                     out_valid_q <= 1'b1;
                     taken_q     <= taken_d;
                     next_pc_q   <= next_pc_d;
                     if (mispred) begin
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= next_pc_d;
                        state_q       <= ST_SQUASH;
                        cnt_q         <= SQ_INIT;
                     end
                  end
               end
               ST_SQUASH: begin
                  if (cnt_q == '0) begin
                     state_q <= ST_RUN;
                  end else if (bus.in_valid) begin
                     cnt_q <= cnt_q - 1'b1;
                     if (cnt_q == CNT_W'(1)) state_q <= ST_RUN;
                  end
               end
               default: state_q <= ST_RUN;
            endcase
         end
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.taken       = taken_q;
   assign bus.next_pc     = next_pc_q;
   assign bus.redirect    = redirect_q;
   assign bus.redirect_pc = redirect_pc_q;

`ifdef BRANCH_STATS_EN
   logic [31:0] br_cnt_q;
   logic [31:0] mp_cnt_q;

   // Saturating counters of resolved branches and issued redirects.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         br_cnt_q <= '0;
         mp_cnt_q <= '0;
      end else if (!bus.flush && run_acc) begin
         if (bus.is_branch) br_cnt_q <= sat_inc32(br_cnt_q);
         if (mispred)       mp_cnt_q <= sat_inc32(mp_cnt_q);
      end
   end

   assign bus.stat_branches = br_cnt_q;
   assign bus.stat_mispred  = mp_cnt_q;
`else
   assign bus.stat_branches = 32'd0;
   assign bus.stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Self-checking bench for branch_resolve_stage: directed vectors, a
// relation-set reference model compared every cycle, plus literal checks.
module tb_branch_resolve_stage;
   import branch_resolve_stage_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   branch_resolve_stage_if #(.ADDR_W(32)) bus ();

   branch_resolve_stage #(.ADDR_W(32), .PC_STEP(1), .SQUASH_CYC(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Comparator outcome is one relation out of {eq, lt, gt}; each condition
   // code is the set of relations for which it holds.
   bit          m_ov, m_taken, m_redir;
   logic [31:0] m_npc, m_rpc;
   int          m_drop, m_nbr, m_nmp;

   function automatic bit m_cond(input logic [2:0] op, input logic e, input logic l, input logic g);
      logic [2:0] sets [8];
      sets = '{3'b001, 3'b110, 3'b010, 3'b101, 3'b100, 3'b011, 3'b111, 3'b000};
      if (op == 3'd6) return 1'b1;
      return |(sets[op] & {g, l, e});
   endfunction

   function automatic bit m_in_ready();
      return (m_drop > 0) || !m_ov || bus.out_ready;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      bit acc, t;
      if (!reset_n) begin
         m_ov = 0; m_taken = 0; m_redir = 0; m_npc = 0; m_rpc = 0;
         m_drop = 0; m_nbr = 0; m_nmp = 0;
      end else begin
         acc = bus.in_valid && m_in_ready();
         m_redir = 0;
         if (bus.flush) begin
            m_ov = 0;
            m_drop = 0;
         end else begin
            if (m_ov && bus.out_ready) m_ov = 0;
            if (m_drop > 0) begin
               if (bus.in_valid) m_drop--;
            end else if (acc) begin
               t = bus.is_branch && m_cond(bus.br_op, bus.cmp_eq, bus.cmp_lt, bus.cmp_gt);
               m_ov = 1;
               m_taken = t;
               m_npc = t ? bus.pc + bus.offset : bus.pc + 32'd1;
               if (bus.is_branch) m_nbr++;
               if (bus.is_branch && (t != bus.pred_taken)) begin
                  m_redir = 1; m_rpc = m_npc; m_nmp++; m_drop = 2;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("in_ready", bus.in_ready, m_in_ready());
         chk("out_valid", bus.out_valid, m_ov);
         chk("redirect", bus.redirect, m_redir);
         if (m_ov) begin
            chk("taken", bus.taken, m_taken);
            chk("next_pc", bus.next_pc, m_npc);
         end
         if (m_redir) chk("redirect_pc", bus.redirect_pc, m_rpc);
`ifdef BRANCH_STATS_EN
         chk("stat_branches", bus.stat_branches, m_nbr);
         chk("stat_mispred", bus.stat_mispred, m_nmp);
`else
         chk("stat_branches", bus.stat_branches, 0);
         chk("stat_mispred", bus.stat_mispred, 0);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      bus.in_valid = 0; bus.is_branch = 0; bus.br_op = 3'd0;
      bus.cmp_eq = 0; bus.cmp_lt = 0; bus.cmp_gt = 0; bus.pred_taken = 0;
      bus.pc = 32'd0; bus.offset = 32'd0; bus.flush = 0;
   endtask

   task automatic drive(input bit br, input logic [2:0] op, input bit e, input bit l,
                        input bit g, input bit pt, input logic [31:0] p, input logic [31:0] off);
      bus.in_valid = 1; bus.is_branch = br; bus.br_op = op;
      bus.cmp_eq = e; bus.cmp_lt = l; bus.cmp_gt = g; bus.pred_taken = pt;
      bus.pc = p; bus.offset = off;
   endtask

   task automatic send(input bit br, input logic [2:0] op, input bit e, input bit l,
                       input bit g, input bit pt, input logic [31:0] p, input logic [31:0] off);
      int n;
      n = 0;
      drive(br, op, e, l, g, pt, p, off);
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) chk("send_timeout", 1, 0);
      @(posedge clk); #1;
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int exp_br, exp_mp;
      idle();
      bus.out_ready = 1;
      reset_n = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_redirect", bus.redirect, 0);
      chk("rst_next_pc", bus.next_pc, 0);
      chk("rst_redirect_pc", bus.redirect_pc, 0);
      chk("rst_taken", bus.taken, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      reset_n = 1;
      cmp_en = 1;
      @(posedge clk); #1;

      // BEQ taken, correctly predicted
      send(1, BR_EQ, 1, 0, 0, 1, 32'h100, 32'h20);
      chk("beq_valid", bus.out_valid, 1);
      chk("beq_taken", bus.taken, 1);
      chk("beq_npc", bus.next_pc, 32'h120);
      chk("beq_redirect", bus.redirect, 0);

      // BLT not taken but predicted taken -> redirect, then squash two inputs
      send(1, BR_LT, 0, 0, 1, 1, 32'h200, 32'h40);
      chk("blt_redirect", bus.redirect, 1);
      chk("blt_rpc", bus.redirect_pc, 32'h201);
      chk("blt_npc", bus.next_pc, 32'h201);
      send(0, BR_EQ, 0, 0, 0, 0, 32'h300, 32'h0);
      chk("sq1_redirect_gone", bus.redirect, 0);
      chk("sq1_valid", bus.out_valid, 0);
      send(0, BR_EQ, 0, 0, 0, 0, 32'h301, 32'h0);
      chk("sq2_valid", bus.out_valid, 0);
      send(0, BR_EQ, 0, 0, 0, 0, 32'h302, 32'h0);
      chk("after_sq_valid", bus.out_valid, 1);
      chk("after_sq_npc", bus.next_pc, 32'h303);

      // BGE taken correct; BLE not taken, mispredicted
      send(1, BR_GE, 0, 0, 1, 1, 32'h600, 32'h8);
      chk("bge_npc", bus.next_pc, 32'h608);
      send(1, BR_LE, 0, 0, 1, 1, 32'h700, 32'h8);
      chk("ble_redirect", bus.redirect, 1);
      chk("ble_rpc", bus.redirect_pc, 32'h701);
      send(0, BR_EQ, 0, 0, 0, 0, 32'h710, 32'h0);
      send(0, BR_EQ, 0, 0, 0, 0, 32'h711, 32'h0);

      // JMP wraps modulo 2^32
      send(1, BR_JMP, 0, 0, 0, 1, 32'hFFFF_FFF0, 32'h20);
      chk("jmp_wrap_npc", bus.next_pc, 32'h10);
      chk("jmp_taken", bus.taken, 1);
      chk("jmp_redirect", bus.redirect, 0);

`ifdef BRANCH_STATS_EN
      exp_br = 5; exp_mp = 2;
`else
      exp_br = 0; exp_mp = 0;
`endif
      chk("stat_br_5", bus.stat_branches, exp_br);
      chk("stat_mp_2", bus.stat_mispred, exp_mp);

      // Back-pressure: hold output for 3 cycles
      send(0, BR_EQ, 0, 0, 0, 0, 32'h400, 32'h0);
      bus.out_ready = 0;
      drive(0, BR_EQ, 0, 0, 0, 0, 32'h500, 32'h0);
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", bus.in_ready, 0);
         chk("stall_valid", bus.out_valid, 1);
         chk("stall_npc", bus.next_pc, 32'h401);
      end
      @(posedge clk); #1;
      bus.out_ready = 1;
      @(negedge clk);
      chk("release_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      idle();
      chk("release_npc", bus.next_pc, 32'h501);

      // More condition codes
      send(1, BR_NE, 0, 1, 0, 1, 32'h800, 32'h10);
      chk("bne_npc", bus.next_pc, 32'h810);
      send(1, BR_GT, 0, 1, 0, 0, 32'h900, 32'h10);
      chk("bgt_npc", bus.next_pc, 32'h901);
      send(1, BR_RSV, 1, 0, 0, 0, 32'hA00, 32'h10);
      chk("rsv_taken", bus.taken, 0);
      send(0, BR_JMP, 1, 0, 0, 1, 32'hB00, 32'h10);
      chk("nonbr_taken", bus.taken, 0);
      chk("nonbr_npc", bus.next_pc, 32'hB01);
      chk("nonbr_redirect", bus.redirect, 0);

      // Flush together with an accepted mispredict
      drive(1, BR_NE, 1, 0, 0, 1, 32'hC00, 32'h10);
      bus.flush = 1;
      @(posedge clk); #1;
      idle();
      chk("flush_redirect", bus.redirect, 0);
      chk("flush_valid", bus.out_valid, 0);
      send(0, BR_EQ, 0, 0, 0, 0, 32'hD00, 32'h0);
      chk("post_flush_valid", bus.out_valid, 1);
      chk("post_flush_npc", bus.next_pc, 32'hD01);

      // Reset in the middle of a squash window
      send(1, BR_EQ, 0, 1, 0, 1, 32'hE00, 32'h10);
      chk("pre_rst_redirect", bus.redirect, 1);
      send(0, BR_EQ, 0, 0, 0, 0, 32'hE10, 32'h0);
      reset_n = 0;
      #1;
      chk("midrst_valid", bus.out_valid, 0);
      chk("midrst_redirect", bus.redirect, 0);
      chk("midrst_stat_br", bus.stat_branches, 0);
      chk("midrst_stat_mp", bus.stat_mispred, 0);
      @(posedge clk); #1;
      reset_n = 1;
      send(0, BR_EQ, 0, 0, 0, 0, 32'hF00, 32'h0);
      chk("post_rst_valid", bus.out_valid, 1);
      chk("post_rst_npc", bus.next_pc, 32'hF01);

      repeat (2) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
